alarm_ringer: RTL and testbench
===============================

// Module: alarm_ringer
// PURPOSE
//  Downstream consumer of the clock/alarm compare stage. Takes the level 'trigger' (high while
//  time==alarm and secs==0) and runs the ring/snooze/stop sequence: drives the buzzer with a
//  1 s on/off beep, auto-silences after a timeout, and re-rings after a snooze interval.
// PARAMETERS
//  RING_SECS    60   seconds of ringing before auto-stop (>=2)
//  SNOOZE_SECS  300  seconds silent in SNOOZE before re-ring (>=2)
//  MAX_SNOOZE   3    snoozes allowed per alarm event (used only with ALARM_SNOOZE_LIMIT_EN)
// PORTS
//  clk           in   1  system clock (single clock domain)
//  reset         in   1  asynchronous, active-high reset
//  tick_1hz      in   1  one-clk-wide pulse, once per second, synchronous to clk
//  trigger       in   1  alarm match level from the clock block
//  alarm_en      in   1  alarm armed switch; low forces IDLE
//  snooze_btn    in   1  debounced level; rising edge = snooze request
//  stop_btn      in   1  debounced level; rising edge = stop request
//  buzzer        out  1  registered buzzer drive
//  ringing       out  1  registered, high in RINGING
//  snoozing      out  1  registered, high in SNOOZE
//  snooze_count  out  4  registered snoozes taken this event, saturates at 15
// BEHAVIOUR
//  - Reset: state=IDLE; buzzer=0, ringing=0, snoozing=0, snooze_count=0, counters=0.
//    trigger edge register resets to 1 (no ring if trigger is already high at reset release);
//    button edge registers reset to 0.
//  - Edge detect: x_rise = x & ~x_q, x_q <= x every clk, for trigger, snooze_btn, stop_btn.
//  - Latency: an event sampled at clk edge k updates state and all outputs at edge k.
//  - sec_cnt: width $clog2(max(RING_SECS,SNOOZE_SECS)); cleared on every state entry;
//    increments only on tick_1hz.
//  - IDLE: trig_rise & alarm_en -> RINGING, snooze_count<=0, beep<=1. Otherwise hold.
//  - RINGING: buzzer=beep; beep toggles on each tick_1hz.
//      priority: ~alarm_en -> IDLE; stop_rise -> IDLE; snooze_rise (permitted) -> SNOOZE,
//      snooze_count+1 (sat 15); tick_1hz & sec_cnt==RING_SECS-1 -> IDLE (timeout).
//  - SNOOZE: buzzer=0; trig_rise ignored.
//      priority: ~alarm_en -> IDLE; stop_rise -> IDLE;
//      tick_1hz & sec_cnt==SNOOZE_SECS-1 -> RINGING, beep<=1, snooze_count kept.
//  - Simultaneous stop_rise & snooze_rise: stop wins. Snooze_rise in IDLE/SNOOZE: ignored.
//  - Button edge coinciding with a timeout tick: the button action wins.
//  - New trig_rise while RINGING: ignored (no counter restart).
//  - Async reset mid-ring: buzzer drops immediately; no resume after release.
//  - snooze_count holds its last value in IDLE until the next ring event clears it.
// CONFIGURATION
//  ALARM_SNOOZE_LIMIT_EN defined: snooze permitted only while snooze_count < MAX_SNOOZE;
//    a snooze_rise at the limit is ignored (stays RINGING; stop or timeout still apply).
//  Not defined: snooze always permitted; MAX_SNOOZE unused.
// TESTING  (RING_SECS=4, SNOOZE_SECS=5, MAX_SNOOZE=2, tick_1hz every 10 clks)
//  1 alarm_en=1, trigger 0->1 -> ringing=1, buzzer=1 at same edge; buzzer toggles each tick;
//    after 4 ticks -> IDLE, buzzer=0; trigger held high gives no re-ring.
//  2 ringing, snooze_btn rise -> snoozing=1, buzzer=0, snooze_count=1; 5 ticks later ringing=1,
//    buzzer=1; stop_btn rise -> IDLE, snooze_count stays 1.
//  3 ringing, snooze_btn and stop_btn rise same clk -> IDLE, snooze_count=0.
//  4 with ALARM_SNOOZE_LIMIT_EN: third snooze_rise at count=2 ignored, ringing stays 1,
//    times out after 4 ticks; without macro: third snooze accepted, count=3.
//  5 alarm_en=0 with trigger rise -> stays IDLE; alarm_en 1->0 during SNOOZE -> IDLE next edge.
//  6 reset pulsed mid-RINGING with trigger held high -> all outputs 0; no ring after release.

Source files
------------

// File: rtl/alarm_ringer.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_ringer
//  Purpose  : Runs the ring / snooze / stop sequence behind the alarm compare
//             stage. It drives a 1 s on/off beep, stops ringing after a
//             timeout, and rings again after a snooze interval.
//  Options  : ALARM_SNOOZE_LIMIT_EN - when defined, at most MAX_SNOOZE
//             snoozes are allowed per alarm event.
//  Revision : 1.0 - initial release
// ============================================================================
module alarm_ringer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       trigger,
  input  logic       alarm_en,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_count
);

  localparam int C_MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int C_CW       = $clog2(C_MAX_SECS);
  localparam logic [C_CW-1:0] C_RING_LAST   = C_CW'(RING_SECS - 1);
  localparam logic [C_CW-1:0] C_SNOOZE_LAST = C_CW'(SNOOZE_SECS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [C_CW-1:0] sec_cnt_q;
  logic            beep_q;
  logic            buzzer_q;
  logic            ringing_q;
  logic            snoozing_q;
  logic [3:0]      snooze_count_q;
  logic [3:0]      snooze_count_d;

  logic            trig_q;
  logic            snooze_btn_q;
  logic            stop_btn_q;
  logic            trig_rise;
  logic            snooze_rise;
  logic            stop_rise;
  logic            snooze_ok;

  // Previous-cycle copies of the level inputs for rising-edge detection.
  // The trigger copy resets high so a trigger already asserted at reset
  // release does not start a ring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q       <= 1'b1;
      snooze_btn_q <= 1'b0;
      stop_btn_q   <= 1'b0;
    end else begin
      trig_q       <= trigger;
      snooze_btn_q <= snooze_btn;
      stop_btn_q   <= stop_btn;
    end
  end

  assign trig_rise   = trigger    & ~trig_q;
  assign snooze_rise = snooze_btn & ~snooze_btn_q;
  assign stop_rise   = stop_btn   & ~stop_btn_q;

  // Saturating increment of the snooze counter.
  assign snooze_count_d = (snooze_count_q == 4'hF) ? 4'hF : snooze_count_q + 4'd1;

`ifdef ALARM_SNOOZE_LIMIT_EN
  assign snooze_ok = (snooze_count_q < 4'(MAX_SNOOZE));
`else
  // Snooze is always allowed; MAX_SNOOZE only matters in the limited build.
  logic unused_max_snooze;
  assign unused_max_snooze = (MAX_SNOOZE > 0);
  assign snooze_ok         = 1'b1;
`endif

  // Ring/snooze state machine with registered outputs that change on the
  // same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sec_cnt_q      <= '0;
      beep_q         <= 1'b0;
      buzzer_q       <= 1'b0;
      ringing_q      <= 1'b0;
      snoozing_q     <= 1'b0;
      snooze_count_q <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trig_rise && alarm_en) begin
            state_q        <= S_RINGING;
            sec_cnt_q      <= '0;
            beep_q         <= 1'b1;
            buzzer_q       <= 1'b1;
            ringing_q      <= 1'b1;
            snoozing_q     <= 1'b0;
            snooze_count_q <= 4'd0;
          end
        end

        S_RINGING: begin
          if (!alarm_en || stop_rise) begin
            state_q    <= S_IDLE;
            sec_cnt_q  <= '0;
            buzzer_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
          end else if (snooze_rise && snooze_ok) begin
            state_q        <= S_SNOOZE;
            sec_cnt_q      <= '0;
            buzzer_q       <= 1'b0;
            ringing_q      <= 1'b0;
            snoozing_q     <= 1'b1;
            snooze_count_q <= snooze_count_d;
          end else if (tick_1hz) begin
            if (sec_cnt_q == C_RING_LAST) begin
              // Nobody answered: go quiet.
              state_q    <= S_IDLE;
              sec_cnt_q  <= '0;
              buzzer_q   <= 1'b0;
              ringing_q  <= 1'b0;
              snoozing_q <= 1'b0;
            end else begin
              sec_cnt_q <= sec_cnt_q + 1'b1;
              beep_q    <= ~beep_q;
              buzzer_q  <= ~beep_q;
            end
          end
        end

        S_SNOOZE: begin
          if (!alarm_en || stop_rise) begin
            state_q    <= S_IDLE;
            sec_cnt_q  <= '0;
            buzzer_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
          end else if (tick_1hz) begin
            if (sec_cnt_q == C_SNOOZE_LAST) begin
              // Snooze over: ring again, keeping the snooze tally.
              state_q    <= S_RINGING;
              sec_cnt_q  <= '0;
              beep_q     <= 1'b1;
              buzzer_q   <= 1'b1;
              ringing_q  <= 1'b1;
              snoozing_q <= 1'b0;
            end else begin
              sec_cnt_q <= sec_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q    <= S_IDLE;
          sec_cnt_q  <= '0;
          buzzer_q   <= 1'b0;
          ringing_q  <= 1'b0;
          snoozing_q <= 1'b0;
        end
      endcase
    end
  end

  assign buzzer       = buzzer_q;
  assign ringing      = ringing_q;
  assign snoozing     = snoozing_q;
  assign snooze_count = snooze_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ringer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alarm_ringer
//  Purpose  : Directed scoreboard bench for alarm_ringer
//             (RING_SECS=4, SNOOZE_SECS=5, MAX_SNOOZE=2, tick every 10 clks).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_ringer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       trigger = 1'b0;
  logic       alarm_en = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [3:0] snooze_count;

  alarm_ringer #(
    .RING_SECS  (4),
    .SNOOZE_SECS(5),
    .MAX_SNOOZE (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .trigger     (trigger),
    .alarm_en    (alarm_en),
    .snooze_btn  (snooze_btn),
    .stop_btn    (stop_btn),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .snooze_count(snooze_count)
  );

  always #5 clk = ~clk;

  // Expected {buzzer, ringing, snoozing, snooze_count} after a given edge.
  typedef struct {
    string      name;
    logic [6:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam logic [3:0] C_CNT4 = 4'd2;
`else
  localparam logic [3:0] C_CNT4 = 4'd3;
`endif

  function automatic void expect_o(string n, logic b, logic r, logic s, logic [3:0] c);
    exp_t e;
    e.name = n;
    e.exp  = {b, r, s, c};
    q.push_back(e);
  endfunction

  // Monitor: on each falling edge, compare every pending expectation.
  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = {buzzer, ringing, snoozing, snooze_count};
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got buz=%b ring=%b snz=%b cnt=%0d, want buz=%b ring=%b snz=%b cnt=%0d",
                   e.name, act[6], act[5], act[4], act[3:0],
                   e.exp[6], e.exp[5], e.exp[4], e.exp[3:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic clkn(int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  // Nine quiet clocks, then a tick sampled on the tenth edge.
  task automatic do_tick();
    clkn(9);
    tick_1hz = 1'b1;
    clk1();
    tick_1hz = 1'b0;
  endtask

  initial begin
    // Reset state
    clkn(3);
    expect_o("reset_hold", 0, 0, 0, 4'd0);
    reset = 1'b0;
    clk1();
    expect_o("reset_state", 0, 0, 0, 4'd0);

    // 1: ring, beep toggles per tick, timeout after 4 ticks, no re-ring
    alarm_en = 1'b1;
    trigger  = 1'b1;
    clk1();
    expect_o("t1_ring", 1, 1, 0, 4'd0);
    do_tick(); expect_o("t1_tick1", 0, 1, 0, 4'd0);
    do_tick(); expect_o("t1_tick2", 1, 1, 0, 4'd0);
    do_tick(); expect_o("t1_tick3", 0, 1, 0, 4'd0);
    do_tick(); expect_o("t1_timeout", 0, 0, 0, 4'd0);
    clkn(20);
    expect_o("t1_no_rering", 0, 0, 0, 4'd0);
    trigger = 1'b0;
    clk1();

    // 2: snooze, re-ring after 5 ticks, stop keeps count
    trigger = 1'b1;
    clk1();
    expect_o("t2_ring", 1, 1, 0, 4'd0);
    trigger    = 1'b0;
    snooze_btn = 1'b1;
    clk1();
    expect_o("t2_snooze", 0, 0, 1, 4'd1);
    snooze_btn = 1'b0;
    do_tick();
    trigger = 1'b1;
    clk1();
    expect_o("t2_trig_in_snooze", 0, 0, 1, 4'd1);
    trigger = 1'b0;
    do_tick(); do_tick(); do_tick();
    expect_o("t2_snooze_tick4", 0, 0, 1, 4'd1);
    do_tick();
    expect_o("t2_rering", 1, 1, 0, 4'd1);
    stop_btn = 1'b1;
    clk1();
    expect_o("t2_stop", 0, 0, 0, 4'd1);
    stop_btn = 1'b0;
    clk1();

    // 3: snooze and stop on the same edge -> stop wins
    trigger = 1'b1;
    clk1();
    expect_o("t3_ring", 1, 1, 0, 4'd0);
    trigger    = 1'b0;
    snooze_btn = 1'b1;
    stop_btn   = 1'b1;
    clk1();
    expect_o("t3_stop_wins", 0, 0, 0, 4'd0);
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
    clk1();

    // 4: snooze limit
    trigger = 1'b1;
    clk1();
    trigger    = 1'b0;
    snooze_btn = 1'b1;
    clk1();
    expect_o("t4_snooze1", 0, 0, 1, 4'd1);
    snooze_btn = 1'b0;
    for (int i = 0; i < 5; i++) do_tick();
    expect_o("t4_rering1", 1, 1, 0, 4'd1);
    snooze_btn = 1'b1;
    clk1();
    expect_o("t4_snooze2", 0, 0, 1, 4'd2);
    snooze_btn = 1'b0;
    for (int i = 0; i < 5; i++) do_tick();
    expect_o("t4_rering2", 1, 1, 0, 4'd2);
    snooze_btn = 1'b1;
    clk1();
`ifdef ALARM_SNOOZE_LIMIT_EN
    expect_o("t4_snooze3_ignored", 1, 1, 0, 4'd2);
    snooze_btn = 1'b0;
    for (int i = 0; i < 3; i++) do_tick();
    expect_o("t4_tick3", 0, 1, 0, 4'd2);
    do_tick();
    expect_o("t4_timeout", 0, 0, 0, 4'd2);
`else
    expect_o("t4_snooze3", 0, 0, 1, 4'd3);
    snooze_btn = 1'b0;
    stop_btn   = 1'b1;
    clk1();
    expect_o("t4_stop", 0, 0, 0, 4'd3);
    stop_btn = 1'b0;
`endif
    clk1();

    // 5: alarm disabled ignores trigger; disabling during snooze -> IDLE
    alarm_en = 1'b0;
    trigger  = 1'b1;
    clk1();
    expect_o("t5_disabled", 0, 0, 0, C_CNT4);
    clkn(3);
    trigger  = 1'b0;
    alarm_en = 1'b1;
    clk1();
    expect_o("t5_idle_hold", 0, 0, 0, C_CNT4);
    trigger = 1'b1;
    clk1();
    expect_o("t5_ring", 1, 1, 0, 4'd0);
    trigger    = 1'b0;
    snooze_btn = 1'b1;
    clk1();
    expect_o("t5_snooze", 0, 0, 1, 4'd1);
    snooze_btn = 1'b0;
    clk1();
    alarm_en = 1'b0;
    clk1();
    expect_o("t5_disable_in_snooze", 0, 0, 0, 4'd1);
    alarm_en = 1'b1;
    clk1();

    // Stop pressed on the same edge as the snooze-expiry tick -> IDLE
    trigger = 1'b1;
    clk1();
    trigger    = 1'b0;
    snooze_btn = 1'b1;
    clk1();
    snooze_btn = 1'b0;
    for (int i = 0; i < 4; i++) do_tick();
    clkn(9);
    tick_1hz = 1'b1;
    stop_btn = 1'b1;
    clk1();
    tick_1hz = 1'b0;
    expect_o("t5_stop_beats_tick", 0, 0, 0, 4'd1);
    stop_btn = 1'b0;
    clk1();

    // 6: async reset mid-ring with trigger held high
    trigger = 1'b1;
    clk1();
    expect_o("t6_ring", 1, 1, 0, 4'd0);
    clkn(3);
    #1;
    reset = 1'b1;
    expect_o("t6_reset_async", 0, 0, 0, 4'd0);
    clk1();
    reset = 1'b0;
    clkn(20);
    expect_o("t6_no_ring_after", 0, 0, 0, 4'd0);
    trigger = 1'b0;

    clkn(3);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
